// File: rtl/rmw_engine.sv
// Read-modify-write engine: reads one memory word, applies ADD/SUB/XOR/SATADD with the request operand, writes it back.
// Latency: accept -> READ 1 cycle -> MODIFY MOD_LAT cycles -> WRITE 1 cycle -> result valid; accept-to-accept is 4+MOD_LAT minimum.
// Backpressure: one transaction in flight; ready_in only in IDLE; DONE holds valid_out until ready_out, and requests are not queued.
module rmw_engine #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 4,
  parameter int MOD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  output logic              ready_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] operand_in,
  input  logic [1:0]        op_in,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              valid_out,
  input  logic              ready_out,
  output logic [DATA_W-1:0] result_out,
  output logic [ADDR_W-1:0] addr_out,
  output logic              reload,
  output logic              busy
);

  localparam int CNT_W = $clog2(MOD_LAT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_MODIFY,
    S_WRITE,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_operand;
  logic [DATA_W-1:0]   r_old;
  logic [1:0]          r_op;
  logic [CNT_W-1:0]    r_cnt;

  logic                w_first;
  logic [DATA_W-1:0]   w_old;
  logic [DATA_W:0]     w_sum;
  logic [DATA_W-1:0]   w_result;

  // The counter is loaded with MOD_LAT on entry, so a full count marks the first MODIFY cycle.
  // Read data is only guaranteed on that cycle, so it is used directly there (needed when MOD_LAT=1).
  assign w_first = (r_cnt == CNT_W'(MOD_LAT));
  assign w_old   = w_first ? mem_rdata : r_old;
  assign w_sum   = {1'b0, w_old} + {1'b0, r_operand};

  // Operation select; the carry-out of the widened sum drives the saturating clamp.
  always_comb begin
    w_result = '0;
    case (r_op)
      2'b00:   w_result = w_sum[DATA_W-1:0];
      2'b01:   w_result = w_old - r_operand;
      2'b10:   w_result = w_old ^ r_operand;
      default: w_result = w_sum[DATA_W] ? '1 : w_sum[DATA_W-1:0];
    endcase
  end

  // Control FSM; all outputs are registered and set on the transition into the state that owns them.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_operand  <= '0;
      r_old      <= '0;
      r_op       <= '0;
      r_cnt      <= '0;
      ready_in   <= 1'b1;
      busy       <= 1'b0;
      mem_re     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      reload     <= 1'b0;
      valid_out  <= 1'b0;
      result_out <= '0;
      addr_out   <= '0;
    end else begin
      // Strobes and memory buses default low/zero every cycle.
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      reload    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      case (r_state)
        S_IDLE: begin
          if (valid_in && ready_in) begin
            r_addr    <= addr_in;
            r_operand <= operand_in;
            r_op      <= op_in;
            r_state   <= S_READ;
            ready_in  <= 1'b0;
            busy      <= 1'b1;
            mem_re    <= 1'b1;
            mem_addr  <= addr_in;
          end
        end
        S_READ: begin
          r_state <= S_MODIFY;
          r_cnt   <= CNT_W'(MOD_LAT);
        end
        S_MODIFY: begin
          if (w_first) begin
            r_old <= mem_rdata;
          end
          if (r_cnt == CNT_W'(1)) begin
            r_state   <= S_WRITE;
            r_cnt     <= '0;
            mem_we    <= 1'b1;
            mem_addr  <= r_addr;
            mem_wdata <= w_result;
            reload    <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_WRITE: begin
          r_state    <= S_DONE;
          valid_out  <= 1'b1;
          result_out <= mem_wdata;
          addr_out   <= r_addr;
        end
        S_DONE: begin
          if (ready_out) begin
            r_state   <= S_IDLE;
            valid_out <= 1'b0;
            ready_in  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
